// File: rtl/imem_loader.sv
// imem_loader: byte-stream programmer for the instruction memory write port.
// Accepts a framed image (SYNC, LEN, BASE, 4*LEN data bytes MSB first, CHK),
// writes each completed big-endian word to IMEM and reports the start PC.
module imem_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_WORDS = 64,
  parameter int         ADDR_W    = 8
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic [7:0]        LD_byte,
  input  logic              LD_valid,
  output logic              LD_ready,
  output logic              LD_wr_en,
  output logic [ADDR_W-1:0] LD_wr_addr,
  output logic [31:0]       LD_wr_data,
  output logic              LD_busy,
  output logic              LD_done,
  output logic [ADDR_W-1:0] LD_start_pc,
  output logic              LD_error,
  output logic [1:0]        LD_err_code
);

  // Range check is done two bits wider than the address so BASE+4*LEN never wraps.
  localparam int SUM_W = ADDR_W + 2;
  localparam logic [SUM_W-1:0] ADDR_LIMIT = {2'b01, {ADDR_W{1'b0}}};

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_CHK   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_BASE, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          rem_q, rem_d;        // words still to be written
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [23:0]         shift_q, shift_d;    // first three bytes of the word in flight
  logic [31:0]         wdata_q, wdata_d;    // only changes when a word completes
  logic [1:0]          cnt_q, cnt_d;        // bytes received of the current word
  logic [7:0]          chk_q, chk_d;        // running XOR of LEN, BASE and data
  logic [ADDR_W-1:0]   start_pc_q, start_pc_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                ready;
  logic                accept;
  logic [SUM_W-1:0]    end_addr;

  assign ready    = (state_q == S_IDLE) || (state_q == S_LEN) || (state_q == S_BASE) ||
                    (state_q == S_DATA) || (state_q == S_CHK);
  assign accept   = LD_valid & ready;
  assign end_addr = SUM_W'(LD_byte) + (SUM_W'(len_q) << 2);

  // Next-state and datapath updates for the frame parser.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rem_d      = rem_q;
    base_d     = base_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    chk_d      = chk_q;
    start_pc_d = start_pc_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (accept && (LD_byte == SYNC_BYTE)) begin
          state_d    = S_LEN;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end

      S_LEN: begin
        if (accept) begin
          len_d = LD_byte;
          rem_d = LD_byte;
          chk_d = LD_byte;
          if ((LD_byte == 8'd0) || (int'(LD_byte) > MAX_WORDS)) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_RANGE;
          end else begin
            state_d = S_BASE;
          end
        end
      end

      S_BASE: begin
        if (accept) begin
          if (LD_byte[1:0] != 2'b00) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_ALIGN;
          end else if (end_addr > ADDR_LIMIT) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_RANGE;
          end else begin
            state_d = S_DATA;
            base_d  = ADDR_W'(LD_byte);
            addr_d  = ADDR_W'(LD_byte);
            chk_d   = chk_q ^ LD_byte;
            cnt_d   = 2'd0;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          chk_d   = chk_q ^ LD_byte;
          cnt_d   = cnt_q + 2'd1;
          shift_d = {shift_q[15:0], LD_byte};
          if (cnt_q == 2'd3) begin
            wdata_d = {shift_q, LD_byte};
            state_d = S_WRITE;
          end
        end
      end

      // Single strobe cycle; address advances once the write has been seen.
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(4);
        rem_d   = rem_q - 8'd1;
        state_d = (rem_q == 8'd1) ? S_CHK : S_DATA;
      end

      S_CHK: begin
        if (accept) begin
          if (LD_byte == chk_q) begin
            state_d    = S_DONE;
            start_pc_d = base_q;
          end else begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops any partial frame without writing.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rem_q      <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      chk_q      <= '0;
      start_pc_q <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      chk_q      <= chk_d;
      start_pc_q <= start_pc_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign LD_ready    = ready;
  assign LD_wr_en    = (state_q == S_WRITE);
  assign LD_wr_addr  = addr_q;
  assign LD_wr_data  = wdata_q;
  assign LD_busy     = (state_q != S_IDLE);
  assign LD_done     = (state_q == S_DONE);
  assign LD_start_pc = start_pc_q;
  assign LD_error    = err_q;
  assign LD_err_code = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good frames, garbage, stalls, errors, reset.
module tb_imem_loader;
  logic        SYS_clk = 1'b0;
  logic        SYS_reset = 1'b1;
  logic [7:0]  LD_byte = 8'h00;
  logic        LD_valid = 1'b0;
  logic        LD_ready, LD_wr_en, LD_busy, LD_done, LD_error;
  logic [7:0]  LD_wr_addr, LD_start_pc;
  logic [31:0] LD_wr_data;
  logic [1:0]  LD_err_code;

  int total = 0;
  int bad = 0;

  // Monitor state, sampled on the falling edge.
  int          wr_n = 0;
  logic [7:0]  wr_addr_log [0:7];
  logic [31:0] wr_data_log [0:7];
  int          done_n = 0;
  logic [7:0]  done_pc = 8'h00;
  int          b2b_n = 0;
  int          bad_ready_n = 0;
  logic        prev_wr = 1'b0;

  imem_loader dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .LD_byte(LD_byte), .LD_valid(LD_valid),
    .LD_ready(LD_ready), .LD_wr_en(LD_wr_en), .LD_wr_addr(LD_wr_addr),
    .LD_wr_data(LD_wr_data), .LD_busy(LD_busy), .LD_done(LD_done),
    .LD_start_pc(LD_start_pc), .LD_error(LD_error), .LD_err_code(LD_err_code)
  );

  always #5 SYS_clk = ~SYS_clk;

  // Log write strobes and done pulses; flag ready drops outside WRITE/DONE/ERR.
  always @(negedge SYS_clk) begin
    if (LD_wr_en) begin
      if (wr_n < 8) begin
        wr_addr_log[wr_n] = LD_wr_addr;
        wr_data_log[wr_n] = LD_wr_data;
      end
      wr_n = wr_n + 1;
      if (prev_wr) b2b_n = b2b_n + 1;
    end
    prev_wr = LD_wr_en;
    if (LD_done) begin
      done_n  = done_n + 1;
      done_pc = LD_start_pc;
    end
    if (!SYS_reset && !LD_ready && !LD_wr_en && !LD_done && !(LD_busy && LD_error))
      bad_ready_n = bad_ready_n + 1;
  end

  task automatic clear_mon();
    wr_n = 0; done_n = 0; b2b_n = 0; bad_ready_n = 0;
  endtask

  // Present one byte (called at a falling edge), wait for acceptance.
  task automatic send(input logic [7:0] b, input bit gap);
    int guard = 0;
    LD_byte  = b;
    LD_valid = 1'b1;
    while (!LD_ready && guard < 20) begin
      @(negedge SYS_clk);
      guard++;
    end
    total++;
    if (guard >= 20) begin
      bad++;
      $display("FAIL send_timeout byte=%h ready stayed %b, required 1", b, LD_ready);
    end
    @(negedge SYS_clk);
    if (gap) begin
      LD_valid = 1'b0;
      @(negedge SYS_clk);
    end
  endtask

  task automatic idle(input int n);
    LD_valid = 1'b0;
    repeat (n) @(negedge SYS_clk);
  endtask

  task automatic send_basic();
    send(8'hA5, 0); send(8'h01, 0); send(8'h10, 0); send(8'h20, 0);
    send(8'h09, 0); send(8'h00, 0); send(8'h05, 0); send(8'h3D, 0);
  endtask

  task automatic test_reset();
    SYS_reset = 1'b1;
    repeat (2) @(negedge SYS_clk);
    total += 9;
    if (LD_wr_en !== 1'b0)    begin bad++; $display("FAIL rst_wr_en got %b want 0", LD_wr_en); end
    if (LD_ready !== 1'b1)    begin bad++; $display("FAIL rst_ready got %b want 1", LD_ready); end
    if (LD_busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got %b want 0", LD_busy); end
    if (LD_done !== 1'b0)     begin bad++; $display("FAIL rst_done got %b want 0", LD_done); end
    if (LD_error !== 1'b0)    begin bad++; $display("FAIL rst_error got %b want 0", LD_error); end
    if (LD_err_code !== 2'd0) begin bad++; $display("FAIL rst_code got %0d want 0", LD_err_code); end
    if (LD_start_pc !== 8'h0) begin bad++; $display("FAIL rst_pc got %h want 00", LD_start_pc); end
    if (LD_wr_addr !== 8'h0)  begin bad++; $display("FAIL rst_addr got %h want 00", LD_wr_addr); end
    if (LD_wr_data !== 32'h0) begin bad++; $display("FAIL rst_data got %h want 0", LD_wr_data); end
    SYS_reset = 1'b0;
    @(negedge SYS_clk);
  endtask

  task automatic test_basic();
    clear_mon();
    send_basic();
    idle(4);
    total += 9;
    if (wr_n !== 1) begin bad++; $display("FAIL basic_wr_n got %0d want 1", wr_n); end
    if (wr_addr_log[0] !== 8'h10) begin bad++; $display("FAIL basic_addr got %h want 10", wr_addr_log[0]); end
    if (wr_data_log[0] !== 32'h20090005) begin bad++; $display("FAIL basic_data got %h want 20090005", wr_data_log[0]); end
    if (done_n !== 1) begin bad++; $display("FAIL basic_done_n got %0d want 1", done_n); end
    if (done_pc !== 8'h10) begin bad++; $display("FAIL basic_done_pc got %h want 10", done_pc); end
    if (LD_start_pc !== 8'h10) begin bad++; $display("FAIL basic_pc got %h want 10", LD_start_pc); end
    if (LD_error !== 1'b0) begin bad++; $display("FAIL basic_error got %b want 0", LD_error); end
    if (LD_busy !== 1'b0) begin bad++; $display("FAIL basic_busy got %b want 0", LD_busy); end
    if (LD_wr_data !== 32'h20090005) begin bad++; $display("FAIL basic_hold got %h want 20090005", LD_wr_data); end
  endtask

  task automatic test_garbage();
    clear_mon();
    send(8'h00, 0); send(8'hFF, 0); send(8'h13, 0);
    send_basic();
    idle(4);
    total += 5;
    if (wr_n !== 1) begin bad++; $display("FAIL garb_wr_n got %0d want 1", wr_n); end
    if (wr_addr_log[0] !== 8'h10 || wr_data_log[0] !== 32'h20090005)
      begin bad++; $display("FAIL garb_write got %h:%h want 10:20090005", wr_addr_log[0], wr_data_log[0]); end
    if (done_n !== 1 || LD_start_pc !== 8'h10)
      begin bad++; $display("FAIL garb_done got n=%0d pc=%h want n=1 pc=10", done_n, LD_start_pc); end
    if (bad_ready_n !== 0) begin bad++; $display("FAIL garb_ready_drop got %0d want 0", bad_ready_n); end
    if (b2b_n !== 0) begin bad++; $display("FAIL garb_b2b got %0d want 0", b2b_n); end
  endtask

  // LEN=2 at 0xF8 ends exactly at the top of memory; XOR = 02^F8^11^..^88 = 72.
  task automatic test_toggle();
    clear_mon();
    send(8'hA5, 1); send(8'h02, 1); send(8'hF8, 1);
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h44, 1);
    send(8'h55, 1); send(8'h66, 1); send(8'h77, 1); send(8'h88, 1);
    send(8'h72, 1);
    idle(4);
    total += 7;
    if (wr_n !== 2) begin bad++; $display("FAIL tog_wr_n got %0d want 2", wr_n); end
    if (wr_addr_log[0] !== 8'hF8 || wr_data_log[0] !== 32'h11223344)
      begin bad++; $display("FAIL tog_w0 got %h:%h want F8:11223344", wr_addr_log[0], wr_data_log[0]); end
    if (wr_addr_log[1] !== 8'hFC || wr_data_log[1] !== 32'h55667788)
      begin bad++; $display("FAIL tog_w1 got %h:%h want FC:55667788", wr_addr_log[1], wr_data_log[1]); end
    if (done_n !== 1) begin bad++; $display("FAIL tog_done_n got %0d want 1", done_n); end
    if (LD_start_pc !== 8'hF8) begin bad++; $display("FAIL tog_pc got %h want F8", LD_start_pc); end
    if (LD_error !== 1'b0) begin bad++; $display("FAIL tog_error got %b want 0", LD_error); end
    if (b2b_n !== 0) begin bad++; $display("FAIL tog_b2b got %0d want 0", b2b_n); end
  endtask

  task automatic test_errors();
    clear_mon();
    send(8'hA5, 0); send(8'h00, 0); idle(3);
    total += 3;
    if (LD_error !== 1'b1 || LD_err_code !== 2'd1)
      begin bad++; $display("FAIL err_len0 got err=%b code=%0d want 1/1", LD_error, LD_err_code); end
    if (wr_n !== 0) begin bad++; $display("FAIL err_len0_wr got %0d want 0", wr_n); end
    if (LD_busy !== 1'b0) begin bad++; $display("FAIL err_busy got %b want 0", LD_busy); end

    send(8'hA5, 0); send(8'h01, 0); send(8'h11, 0); idle(3);
    total += 1;
    if (LD_error !== 1'b1 || LD_err_code !== 2'd2)
      begin bad++; $display("FAIL err_align got err=%b code=%0d want 1/2", LD_error, LD_err_code); end

    send(8'hA5, 0); send(8'h02, 0); send(8'hFC, 0); idle(3);
    total += 2;
    if (LD_error !== 1'b1 || LD_err_code !== 2'd1)
      begin bad++; $display("FAIL err_range got err=%b code=%0d want 1/1", LD_error, LD_err_code); end
    if (wr_n !== 0) begin bad++; $display("FAIL err_range_wr got %0d want 0", wr_n); end

    send(8'hA5, 0); send(8'h01, 0); send(8'h10, 0); send(8'h20, 0);
    send(8'h09, 0); send(8'h00, 0); send(8'h05, 0); send(8'h3C, 0); idle(3);
    total += 4;
    if (LD_error !== 1'b1 || LD_err_code !== 2'd3)
      begin bad++; $display("FAIL err_chk got err=%b code=%0d want 1/3", LD_error, LD_err_code); end
    if (wr_n !== 1) begin bad++; $display("FAIL err_chk_wr got %0d want 1", wr_n); end
    if (LD_start_pc !== 8'hF8) begin bad++; $display("FAIL err_chk_pc got %h want F8", LD_start_pc); end
    if (done_n !== 0) begin bad++; $display("FAIL err_done_n got %0d want 0", done_n); end
  endtask

  // Reset after the 2nd data byte; the next frame (XOR 01^20^DE^AD^BE^EF = 03) must work.
  task automatic test_reset_mid();
    clear_mon();
    send(8'hA5, 0); send(8'h01, 0); send(8'h20, 0); send(8'hDE, 0); send(8'hAD, 0);
    LD_valid  = 1'b0;
    SYS_reset = 1'b1;
    @(negedge SYS_clk);
    SYS_reset = 1'b0;
    idle(6);
    total += 3;
    if (wr_n !== 0) begin bad++; $display("FAIL rmid_wr got %0d want 0", wr_n); end
    if (LD_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got %b want 0", LD_busy); end
    if (LD_start_pc !== 8'h00) begin bad++; $display("FAIL rmid_pc got %h want 00", LD_start_pc); end
    send(8'hA5, 0); send(8'h01, 0); send(8'h20, 0); send(8'hDE, 0);
    send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0); send(8'h03, 0);
    idle(4);
    total += 3;
    if (wr_n !== 1 || wr_addr_log[0] !== 8'h20 || wr_data_log[0] !== 32'hDEADBEEF)
      begin bad++; $display("FAIL rmid_write got n=%0d %h:%h want 1 20:DEADBEEF", wr_n, wr_addr_log[0], wr_data_log[0]); end
    if (done_n !== 1) begin bad++; $display("FAIL rmid_done got %0d want 1", done_n); end
    if (LD_start_pc !== 8'h20) begin bad++; $display("FAIL rmid_pc2 got %h want 20", LD_start_pc); end
  endtask

  task automatic test_err_then_good();
    clear_mon();
    send(8'hA5, 0); send(8'h00, 0); idle(3);
    total += 1;
    if (LD_error !== 1'b1) begin bad++; $display("FAIL etg_err got %b want 1", LD_error); end
    send(8'hA5, 0);
    total += 2;
    if (LD_error !== 1'b0) begin bad++; $display("FAIL etg_clear got %b want 0", LD_error); end
    if (LD_busy !== 1'b1) begin bad++; $display("FAIL etg_busy got %b want 1", LD_busy); end
    send(8'h01, 0); send(8'h10, 0); send(8'h20, 0);
    send(8'h09, 0); send(8'h00, 0); send(8'h05, 0); send(8'h3D, 0);
    idle(4);
    total += 2;
    if (done_n !== 1 || LD_start_pc !== 8'h10)
      begin bad++; $display("FAIL etg_done got n=%0d pc=%h want 1/10", done_n, LD_start_pc); end
    if (LD_error !== 1'b0 || LD_err_code !== 2'd0)
      begin bad++; $display("FAIL etg_code got err=%b code=%0d want 0/0", LD_error, LD_err_code); end
  endtask

  initial begin
    @(negedge SYS_clk);
    test_reset();
    test_basic();
    test_garbage();
    test_toggle();
    test_errors();
    test_reset_mid();
    test_err_then_good();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
